// File: rtl/core_pkg.sv
// Shared core definitions: load funct3 encodings, default widths and the MEM/WB stage record.
package core_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RA_W_DEF = 5;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  // Default-width stage record; parametrised users declare an identically shaped local type.
  typedef struct packed {
    logic                valid;
    logic                RegWrite;
    logic                MemToReg;
    logic [2:0]          funct3;
    logic [XLEN_DEF-1:0] ALUresult;
    logic [XLEN_DEF-1:0] Readdata;
    logic [RA_W_DEF-1:0] rd;
  } mem_wb_stage_t;

endpackage

// File: rtl/load_align.sv
// Combinational load lane select with sign/zero extension; shared with the data-cache refill path.
module load_align
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[{addr_i, 3'b000} +: 8];
    // Halfword lane ignores addr bit 0; misalignment is trapped upstream.
    w_half = word_i[{addr_i[1], 4'b0000} +: 16];
    case (funct3_i)
      LB:      data_o = {{(XLEN-8){w_byte[7]}}, w_byte};
      LH:      data_o = {{(XLEN-16){w_half[15]}}, w_half};
      LBU:     data_o = {{(XLEN-8){1'b0}}, w_byte};
      LHU:     data_o = {{(XLEN-16){1'b0}}, w_half};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: DEPTH-stage chain with stall/flush, load alignment and write-back mux.
// Defining WB_BYPASS_EN adds a one-cycle WB->ID forwarding register (byp_* outputs).
module mem_wb_pipe
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned RA_W  = RA_W_DEF,
  parameter int unsigned DEPTH = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic            RegWrite_i,
  input  logic            MemToReg_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] ALUresult_i,
  input  logic [XLEN-1:0] Readdata_i,
  input  logic [RA_W-1:0] INS_11_7_i,
  output logic            valid_o,
  output logic            RegWrite_o,
  output logic            MemToReg_o,
  output logic [XLEN-1:0] ALUresult_o,
  output logic [XLEN-1:0] Readdata_o,
  output logic [RA_W-1:0] INS_11_7_o,
  output logic            wb_en_o,
`ifdef WB_BYPASS_EN
  output logic            byp_valid_o,
  output logic [RA_W-1:0] byp_rd_o,
  output logic [XLEN-1:0] byp_data_o,
`endif
  output logic [XLEN-1:0] wb_data_o
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [RA_W-1:0] rd;
  } stage_t;

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("mem_wb_pipe: DEPTH must be in 1..4");
  end

  stage_t          r_stage [DEPTH];
  stage_t          w_in;
  stage_t          w_last;
  logic [XLEN-1:0] w_ld;
  logic            w_wb_en;
  logic [XLEN-1:0] w_wb_data;

  always_comb begin
    w_in            = '0;
    w_in.valid      = valid_i;
    w_in.reg_write  = valid_i & RegWrite_i;
    w_in.mem_to_reg = MemToReg_i;
    w_in.funct3     = funct3_i;
    w_in.alu        = ALUresult_i;
    w_in.rdata      = Readdata_i;
    w_in.rd         = INS_11_7_i;
  end

  // Flush only kills valid/RegWrite; data fields keep stale contents.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i].valid     <= 1'b0;
        r_stage[i].reg_write <= 1'b0;
      end
    end else if (!stall_i) begin
      r_stage[0] <= w_in;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign w_last = r_stage[DEPTH-1];

  load_align #(.XLEN(XLEN)) u_load_align (
    .word_i   (w_last.rdata),
    .addr_i   (w_last.alu[1:0]),
    .funct3_i (w_last.funct3),
    .data_o   (w_ld)
  );

  assign w_wb_en   = w_last.valid & w_last.reg_write & (w_last.rd != '0);
  assign w_wb_data = w_last.mem_to_reg ? w_ld : w_last.alu;

  assign valid_o     = w_last.valid;
  assign RegWrite_o  = w_last.reg_write;
  assign MemToReg_o  = w_last.mem_to_reg;
  assign ALUresult_o = w_last.alu;
  assign Readdata_o  = w_ld;
  assign INS_11_7_o  = w_last.rd;
  assign wb_en_o     = w_wb_en;
  assign wb_data_o   = w_wb_data;

`ifdef WB_BYPASS_EN
  logic            r_byp_valid;
  logic [RA_W-1:0] r_byp_rd;
  logic [XLEN-1:0] r_byp_data;

  // Tracks the write port every cycle, including stalled ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_byp_valid <= 1'b0;
      r_byp_rd    <= '0;
      r_byp_data  <= '0;
    end else if (flush_i) begin
      r_byp_valid <= 1'b0;
      r_byp_rd    <= '0;
      r_byp_data  <= '0;
    end else begin
      r_byp_valid <= w_wb_en;
      if (w_wb_en) begin
        r_byp_rd   <= w_last.rd;
        r_byp_data <= w_wb_data;
      end
    end
  end

  assign byp_valid_o = r_byp_valid;
  assign byp_rd_o    = r_byp_rd;
  assign byp_data_o  = r_byp_data;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe at DEPTH=1 and DEPTH=3 against a history-log reference model.
module tb_mem_wb_pipe;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i, RegWrite_i, MemToReg_i;
  logic [2:0]  funct3_i;
  logic [31:0] ALUresult_i, Readdata_i;
  logic [4:0]  INS_11_7_i;

  logic        o_valid [2];
  logic        o_rw    [2];
  logic        o_m2r   [2];
  logic [31:0] o_alu   [2];
  logic [31:0] o_rdata [2];
  logic [4:0]  o_rd    [2];
  logic        o_wben  [2];
  logic [31:0] o_wbd   [2];
`ifdef WB_BYPASS_EN
  logic        o_bv    [2];
  logic [4:0]  o_brd   [2];
  logic [31:0] o_bd    [2];
  logic        m_bv    [2];
  logic [4:0]  m_brd   [2];
  logic [31:0] m_bd    [2];
`endif

  typedef struct packed {
    logic        valid, rw, m2r;
    logic [31:0] alu, rdata;
    logic [4:0]  rd;
    logic        wb_en;
    logic [31:0] wb_data;
  } obs_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            dep [2]  = '{1, 3};
  mem_wb_stage_t hist [$];

  always #5 clk = ~clk;

  mem_wb_pipe #(.XLEN(32), .RA_W(5), .DEPTH(1)) u_d1 (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .funct3_i(funct3_i),
    .ALUresult_i(ALUresult_i), .Readdata_i(Readdata_i), .INS_11_7_i(INS_11_7_i),
    .valid_o(o_valid[0]), .RegWrite_o(o_rw[0]), .MemToReg_o(o_m2r[0]), .ALUresult_o(o_alu[0]),
    .Readdata_o(o_rdata[0]), .INS_11_7_o(o_rd[0]), .wb_en_o(o_wben[0]),
`ifdef WB_BYPASS_EN
    .byp_valid_o(o_bv[0]), .byp_rd_o(o_brd[0]), .byp_data_o(o_bd[0]),
`endif
    .wb_data_o(o_wbd[0]));

  mem_wb_pipe #(.XLEN(32), .RA_W(5), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .funct3_i(funct3_i),
    .ALUresult_i(ALUresult_i), .Readdata_i(Readdata_i), .INS_11_7_i(INS_11_7_i),
    .valid_o(o_valid[1]), .RegWrite_o(o_rw[1]), .MemToReg_o(o_m2r[1]), .ALUresult_o(o_alu[1]),
    .Readdata_o(o_rdata[1]), .INS_11_7_o(o_rd[1]), .wb_en_o(o_wben[1]),
`ifdef WB_BYPASS_EN
    .byp_valid_o(o_bv[1]), .byp_rd_o(o_brd[1]), .byp_data_o(o_bd[1]),
`endif
    .wb_data_o(o_wbd[1]));

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Output of a DEPTH-d pipe is the entry accepted d advances ago, or the reset record.
  function automatic obs_t exp_out(input int d);
    mem_wb_stage_t e;
    obs_t          o;
    e = '0;
    if (hist.size() >= d) e = hist[hist.size() - d];
    o.valid   = e.valid;
    o.rw      = e.RegWrite;
    o.m2r     = e.MemToReg;
    o.alu     = e.ALUresult;
    o.rdata   = ld_ext(e.Readdata, e.ALUresult[1:0], e.funct3);
    o.rd      = e.rd;
    o.wb_en   = e.valid && e.RegWrite && (e.rd != 5'd0);
    o.wb_data = e.MemToReg ? o.rdata : e.ALUresult;
    return o;
  endfunction

  task automatic model_reset();
    hist.delete();
`ifdef WB_BYPASS_EN
    for (int d = 0; d < 2; d++) begin m_bv[d] = 1'b0; m_brd[d] = '0; m_bd[d] = '0; end
`endif
  endtask

  task automatic model_edge();
    mem_wb_stage_t e;
    if (!rst_i) begin model_reset(); return; end
`ifdef WB_BYPASS_EN
    for (int d = 0; d < 2; d++) begin
      obs_t x;
      x = exp_out(dep[d]);
      if (flush_i) begin
        m_bv[d] = 1'b0; m_brd[d] = '0; m_bd[d] = '0;
      end else begin
        m_bv[d] = x.wb_en;
        if (x.wb_en) begin m_brd[d] = x.rd; m_bd[d] = x.wb_data; end
      end
    end
`endif
    if (flush_i) begin
      for (int k = 0; k < 4 && k < hist.size(); k++) begin
        e = hist[hist.size() - 1 - k];
        e.valid = 1'b0;
        e.RegWrite = 1'b0;
        hist[hist.size() - 1 - k] = e;
      end
    end else if (!stall_i) begin
      e.valid     = valid_i;
      e.RegWrite  = valid_i & RegWrite_i;
      e.MemToReg  = MemToReg_i;
      e.funct3    = funct3_i;
      e.ALUresult = ALUresult_i;
      e.Readdata  = Readdata_i;
      e.rd        = INS_11_7_i;
      hist.push_back(e);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  endtask

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (DEPTH=%0d) at %0t: got %h, expected %h", name, d, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    obs_t e;
    for (int d = 0; d < 2; d++) begin
      e = exp_out(dep[d]);
      chk("valid_o",    dep[d], 32'(o_valid[d]), 32'(e.valid));
      chk("RegWrite_o", dep[d], 32'(o_rw[d]),    32'(e.rw));
      chk("wb_en_o",    dep[d], 32'(o_wben[d]),  32'(e.wb_en));
      if (e.valid) begin
        chk("MemToReg_o",  dep[d], 32'(o_m2r[d]), 32'(e.m2r));
        chk("ALUresult_o", dep[d], o_alu[d],      e.alu);
        chk("Readdata_o",  dep[d], o_rdata[d],    e.rdata);
        chk("INS_11_7_o",  dep[d], 32'(o_rd[d]),  32'(e.rd));
        chk("wb_data_o",   dep[d], o_wbd[d],      e.wb_data);
      end
`ifdef WB_BYPASS_EN
      chk("byp_valid_o", dep[d], 32'(o_bv[d]),  32'(m_bv[d]));
      chk("byp_rd_o",    dep[d], 32'(o_brd[d]), 32'(m_brd[d]));
      chk("byp_data_o",  dep[d], o_bd[d],       m_bd[d]);
`endif
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      chk({name, "_valid"}, dep[d], 32'(o_valid[d]), 32'd0);
      chk({name, "_rw"},    dep[d], 32'(o_rw[d]),    32'd0);
      chk({name, "_m2r"},   dep[d], 32'(o_m2r[d]),   32'd0);
      chk({name, "_alu"},   dep[d], o_alu[d],        32'd0);
      chk({name, "_rdata"}, dep[d], o_rdata[d],      32'd0);
      chk({name, "_rd"},    dep[d], 32'(o_rd[d]),    32'd0);
      chk({name, "_wb_en"}, dep[d], 32'(o_wben[d]),  32'd0);
      chk({name, "_wbd"},   dep[d], o_wbd[d],        32'd0);
`ifdef WB_BYPASS_EN
      chk({name, "_bv"},    dep[d], 32'(o_bv[d]),    32'd0);
      chk({name, "_bd"},    dep[d], o_bd[d],         32'd0);
`endif
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] rd);
    valid_i = v; RegWrite_i = rw; MemToReg_i = m2r; funct3_i = f3;
    ALUresult_i = alu; Readdata_i = rdata; INS_11_7_i = rd;
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 3'($urandom),
          $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
    stall_i = ($urandom_range(0, 4) == 0);
    flush_i = ($urandom_range(0, 9) == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b1;

    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd5);
    step();
    chk("pt_wb_en", 1, 32'(o_wben[0]), 32'd1);
    chk("pt_wb_data", 1, o_wbd[0], 32'h0000_1234);

    drive(1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 5'd6);
    step();
    chk("lb_rdata", 1, o_rdata[0], 32'hFFFF_FF80);
    chk("lb_wb_data", 1, o_wbd[0], 32'hFFFF_FF80);
    drive(1'b1, 1'b1, 1'b1, 3'b100, 32'h0000_0003, 32'h80FF_7F01, 5'd6);
    step();
    chk("lbu_rdata", 1, o_rdata[0], 32'h0000_0080);

    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0055, 32'h0, 5'd0);
    step();
    chk("x0_wb_en", 1, 32'(o_wben[0]), 32'd0);
    chk("x0_valid", 1, 32'(o_valid[0]), 32'd1);

    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0, 5'd7);
    step();
    chk("byp_src_wb_en", 1, 32'(o_wben[0]), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0);
    step();
`ifdef WB_BYPASS_EN
    chk("byp_valid_hit", 1, 32'(o_bv[0]), 32'd1);
    chk("byp_rd_hit", 1, 32'(o_brd[0]), 32'd7);
    chk("byp_data_hit", 1, o_bd[0], 32'hDEAD_BEEF);
`endif
    step();
`ifdef WB_BYPASS_EN
    chk("byp_valid_drop", 1, 32'(o_bv[0]), 32'd0);
`endif

    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd1); step();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd2); step();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd3); step();
    chk("fill_alu", 3, o_alu[1], 32'h0000_0100);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd4);
    stall_i = 1'b1;
    step(); step();
    chk("stall_alu", 3, o_alu[1], 32'h0000_0100);
    chk("stall_valid", 3, 32'(o_valid[1]), 32'd1);
    chk("stall_d1_alu", 1, o_alu[0], 32'h0000_0300);
    flush_i = 1'b1;
    step();
    chk("flush_valid", 3, 32'(o_valid[1]), 32'd0);
    chk("flush_valid", 1, 32'(o_valid[0]), 32'd0);
    chk("flush_wb_en", 3, 32'(o_wben[1]), 32'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    for (int n = 0; n < 400; n++) begin
      drive_random();
      step();
    end

    stall_i = 1'b0; flush_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 1'b1, 1'b1, 3'($urandom), $urandom, $urandom, 5'(n + 9));
      step();
    end
    chk("pre_rst_valid", 3, 32'(o_valid[1]), 32'd1);
    #2;
    rst_i = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    step();
    rst_i = 1'b1;

    for (int n = 0; n < 60; n++) begin
      drive_random();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
